// File: rtl/d_phy_hs_tx_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module  : d_phy_hs_tx_sequencer_if
// Purpose : PPI HS transmit handshake plus LP/HS lane drive bundle.
// Rev     : 1.0
// ============================================================================
interface d_phy_hs_tx_sequencer_if #(
  parameter int W = 16
);
  logic         tx_request_hs;
  logic [W-1:0] tx_data_hs;
  logic         tx_ready_hs;
  logic         stop_state;
  logic         lp_dp;
  logic         lp_dn;
  logic         hs_en;
  logic [W-1:0] hs_data;

  modport master (
    output tx_request_hs,
    output tx_data_hs,
    input  tx_ready_hs,
    input  stop_state,
    input  lp_dp,
    input  lp_dn,
    input  hs_en,
    input  hs_data
  );

  modport slave (
    input  tx_request_hs,
    input  tx_data_hs,
    output tx_ready_hs,
    output stop_state,
    output lp_dp,
    output lp_dn,
    output hs_en,
    output hs_data
  );
endinterface
`default_nettype wire

// File: rtl/d_phy_hs_tx_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : d_phy_hs_tx_sequencer
// Purpose : D-PHY data-lane HS burst sequencer (LP-11 .. SYNC .. TRAIL .. EXIT).
// Rev     : 1.0
// ============================================================================
module d_phy_hs_tx_sequencer #(
  parameter int HS_TX_WORD_BIT_WIDTH = 16,
  parameter int T_LPX_CYC            = 2,
  parameter int T_HS_PREPARE_CYC     = 2,
  parameter int T_HS_ZERO_CYC        = 4,
  parameter int T_HS_TRAIL_CYC       = 3,
  parameter int T_HS_EXIT_CYC        = 2
) (
  input  wire logic              hs_tx_word_clk,
  input  wire logic              rst,
  d_phy_hs_tx_sequencer_if.slave ppi
);

  localparam int W       = HS_TX_WORD_BIT_WIDTH;
  localparam int C_MAX_A = (T_LPX_CYC > T_HS_PREPARE_CYC) ? T_LPX_CYC : T_HS_PREPARE_CYC;
  localparam int C_MAX_B = (T_HS_ZERO_CYC > T_HS_TRAIL_CYC) ? T_HS_ZERO_CYC : T_HS_TRAIL_CYC;
  localparam int C_MAX_C = (C_MAX_A > C_MAX_B) ? C_MAX_A : C_MAX_B;
  localparam int C_MAX   = (C_MAX_C > T_HS_EXIT_CYC) ? C_MAX_C : T_HS_EXIT_CYC;
  localparam int CNT_W   = $clog2(C_MAX) + 1;

  localparam logic [CNT_W-1:0] C_LPX_LOAD   = CNT_W'(T_LPX_CYC - 1);
  localparam logic [CNT_W-1:0] C_PREP_LOAD  = CNT_W'(T_HS_PREPARE_CYC - 1);
  localparam logic [CNT_W-1:0] C_ZERO_LOAD  = CNT_W'(T_HS_ZERO_CYC - 1);
  localparam logic [CNT_W-1:0] C_TRAIL_LOAD = CNT_W'(T_HS_TRAIL_CYC - 1);
  localparam logic [CNT_W-1:0] C_EXIT_LOAD  = CNT_W'(T_HS_EXIT_CYC - 1);

  // Sync byte sits in the top byte so it is the last byte serialized (LSB first).
  localparam logic [W-1:0] C_SYNC_WORD = W'(8'hB8) << (W - 8);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LPX     = 3'd1,
    S_PREPARE = 3'd2,
    S_HS_ZERO = 3'd3,
    S_SYNC    = 3'd4,
    S_DATA    = 3'd5,
    S_TRAIL   = 3'd6,
    S_EXIT    = 3'd7
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [W-1:0]     r_word;
  logic             r_trail_lvl;

  logic             w_timer_done;
  logic             w_ready;
  logic             w_accept;
  logic             w_stop;
  logic             w_lp_dp;
  logic             w_lp_dn;
  logic             w_hs_en;
  logic [W-1:0]     w_hs_data;

  assign w_timer_done = (r_cnt == '0);
  assign w_accept     = w_ready & ppi.tx_request_hs;

  always_ff @(posedge hs_tx_word_clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = w_timer_done ? r_cnt : (r_cnt - 1'b1);
    unique case (r_state)
      S_IDLE: begin
        if (ppi.tx_request_hs) begin
          w_state_nxt = S_LPX;
          w_cnt_nxt   = C_LPX_LOAD;
        end
      end
      S_LPX: begin
        if (w_timer_done) begin
          w_state_nxt = S_PREPARE;
          w_cnt_nxt   = C_PREP_LOAD;
        end
      end
      S_PREPARE: begin
        if (w_timer_done) begin
          w_state_nxt = S_HS_ZERO;
          w_cnt_nxt   = C_ZERO_LOAD;
        end
      end
      S_HS_ZERO: begin
        if (w_timer_done) begin
          w_state_nxt = S_SYNC;
        end
      end
      S_SYNC, S_DATA: begin
        // A request dropped during the preamble still lands here and trails out.
        if (ppi.tx_request_hs) begin
          w_state_nxt = S_DATA;
        end else begin
          w_state_nxt = S_TRAIL;
          w_cnt_nxt   = C_TRAIL_LOAD;
        end
      end
      S_TRAIL: begin
        if (w_timer_done) begin
          w_state_nxt = S_EXIT;
          w_cnt_nxt   = C_EXIT_LOAD;
        end
      end
      S_EXIT: begin
        if (w_timer_done) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_comb begin
    w_lp_dp   = 1'b0;
    w_lp_dn   = 1'b0;
    w_hs_en   = 1'b0;
    w_hs_data = '0;
    w_ready   = 1'b0;
    w_stop    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_lp_dp = 1'b1;
        w_lp_dn = 1'b1;
        w_stop  = 1'b1;
      end
      S_LPX: begin
        w_lp_dn = 1'b1;
      end
      S_PREPARE: begin
      end
      S_HS_ZERO: begin
        w_hs_en = 1'b1;
      end
      S_SYNC: begin
        w_hs_en   = 1'b1;
        w_hs_data = C_SYNC_WORD;
        w_ready   = 1'b1;
      end
      S_DATA: begin
        w_hs_en   = 1'b1;
        w_hs_data = r_word;
        w_ready   = 1'b1;
      end
      S_TRAIL: begin
        w_hs_en   = 1'b1;
        w_hs_data = {W{r_trail_lvl}};
      end
      S_EXIT: begin
        w_lp_dp = 1'b1;
        w_lp_dn = 1'b1;
      end
      default: begin
        w_lp_dp = 1'b1;
        w_lp_dn = 1'b1;
      end
    endcase
  end

  // Payload is captured only on accept so idle-bus garbage never reaches hs_data.
  always_ff @(posedge hs_tx_word_clk) begin
    if (rst) begin
      r_word      <= '0;
      r_trail_lvl <= 1'b0;
    end else begin
      if (w_accept) begin
        r_word <= ppi.tx_data_hs;
      end
      if ((r_state == S_SYNC) || (r_state == S_DATA)) begin
        r_trail_lvl <= ~w_hs_data[W-1];
      end
    end
  end

  assign ppi.tx_ready_hs = w_ready;
  assign ppi.stop_state  = w_stop;
  assign ppi.lp_dp       = w_lp_dp;
  assign ppi.lp_dn       = w_lp_dn;
  assign ppi.hs_en       = w_hs_en;
  assign ppi.hs_data     = w_hs_data;

endmodule
`default_nettype wire

// File: tb/tb_d_phy_hs_tx_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_d_phy_hs_tx_sequencer
// Purpose : Scoreboard bench for the D-PHY HS TX sequencer (16-bit and 32-bit).
// Rev     : 1.0
// ============================================================================
module tb_d_phy_hs_tx_sequencer;

  localparam int S_IDLE  = 0;
  localparam int S_LPX   = 1;
  localparam int S_PREP  = 2;
  localparam int S_ZERO  = 3;
  localparam int S_SYNC  = 4;
  localparam int S_DATA  = 5;
  localparam int S_TRAIL = 6;
  localparam int S_EXIT  = 7;

  localparam logic [31:0] C_JUNK = 32'hDEAD_0BAD;

  typedef struct {
    int          which;
    int          st;
    logic [31:0] ed;
    int          sc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  d_phy_hs_tx_sequencer_if #(.W(16)) if16 ();
  d_phy_hs_tx_sequencer_if #(.W(32)) if32 ();

  d_phy_hs_tx_sequencer #(.HS_TX_WORD_BIT_WIDTH(16)) dut16 (
    .hs_tx_word_clk (clk),
    .rst            (rst),
    .ppi            (if16)
  );

  d_phy_hs_tx_sequencer #(.HS_TX_WORD_BIT_WIDTH(32), .T_HS_ZERO_CYC(1)) dut32 (
    .hs_tx_word_clk (clk),
    .rst            (rst),
    .ppi            (if32)
  );

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   sc      = 0;

  // Monitor: one expectation per checked cycle, compared mid-cycle.
  always @(negedge clk) begin
    exp_t        e;
    logic        a_dp, a_dn, a_en, a_rdy, a_stop;
    logic [31:0] a_data;
    logic        x_dp, x_dn, x_en, x_rdy, x_stop, lp_chk;
    logic [31:0] x_data;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (e.which == 0) begin
        a_dp = if16.lp_dp; a_dn = if16.lp_dn; a_en = if16.hs_en;
        a_rdy = if16.tx_ready_hs; a_stop = if16.stop_state;
        a_data = {16'h0, if16.hs_data};
      end else begin
        a_dp = if32.lp_dp; a_dn = if32.lp_dn; a_en = if32.hs_en;
        a_rdy = if32.tx_ready_hs; a_stop = if32.stop_state;
        a_data = if32.hs_data;
      end
      lp_chk = (e.st <= S_ZERO) || (e.st == S_EXIT);
      x_dp   = (e.st == S_IDLE) || (e.st == S_EXIT);
      x_dn   = (e.st == S_IDLE) || (e.st == S_EXIT) || (e.st == S_LPX);
      x_en   = (e.st >= S_ZERO) && (e.st <= S_TRAIL);
      x_rdy  = (e.st == S_SYNC) || (e.st == S_DATA);
      x_stop = (e.st == S_IDLE);
      x_data = ((e.st >= S_SYNC) && (e.st <= S_TRAIL)) ? e.ed : 32'h0;
      n_tests++;
      if ((lp_chk && ((a_dp !== x_dp) || (a_dn !== x_dn))) || (a_en !== x_en) ||
          (a_rdy !== x_rdy) || (a_stop !== x_stop) || (a_data !== x_data)) begin
        n_fail++;
        $display("FAIL scen%0d dut%0d st%0d: got lp=%b%b en=%b data=%h rdy=%b stop=%b, want lp=%b%b en=%b data=%h rdy=%b stop=%b",
                 e.sc, e.which, e.st, a_dp, a_dn, a_en, a_data, a_rdy, a_stop,
                 x_dp, x_dn, x_en, x_data, x_rdy, x_stop);
      end
    end
  end

  task automatic step(input int which, input int st, input logic [31:0] ed,
                      input logic req, input logic [31:0] d);
    exp_t e;
    e.which = which; e.st = st; e.ed = ed; e.sc = sc;
    exp_q.push_back(e);
    if (which == 0) begin
      if16.tx_request_hs = req;
      if16.tx_data_hs    = d[15:0];
    end else begin
      if32.tx_request_hs = req;
      if32.tx_data_hs    = d;
    end
    @(posedge clk);
    #1;
  endtask

  // IDLE cycle with request high, then LPX/PREPARE/HS_ZERO with the given request level.
  task automatic pre(input int which, input int zero_n, input logic req);
    step(which, S_IDLE, 0, 1'b1, C_JUNK);
    for (int i = 0; i < 2; i++) step(which, S_LPX, 0, req, C_JUNK);
    for (int i = 0; i < 2; i++) step(which, S_PREP, 0, req, C_JUNK);
    for (int i = 0; i < zero_n; i++) step(which, S_ZERO, 0, req, C_JUNK);
  endtask

  task automatic tail(input int which, input logic [31:0] trail, input logic req);
    for (int i = 0; i < 3; i++) step(which, S_TRAIL, trail, req, C_JUNK);
    for (int i = 0; i < 2; i++) step(which, S_EXIT, 0, req, C_JUNK);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1);
  end

  initial begin
    if16.tx_request_hs = 1'b0; if16.tx_data_hs = '0;
    if32.tx_request_hs = 1'b0; if32.tx_data_hs = '0;
    rst = 1'b1;
    @(posedge clk); #1;
    sc = 0;
    step(0, S_IDLE, 0, 1'b0, 0);
    step(1, S_IDLE, 0, 1'b0, 0);
    rst = 1'b0;

    // Two-word burst; last word MSB 0 -> trail all ones.
    sc = 1;
    pre(0, 4, 1'b1);
    step(0, S_SYNC, 32'hB800, 1'b1, 32'h1234);
    step(0, S_DATA, 32'h1234, 1'b1, 32'h5678);
    step(0, S_DATA, 32'h5678, 1'b0, C_JUNK);
    tail(0, 32'hFFFF, 1'b0);
    step(0, S_IDLE, 0, 1'b0, C_JUNK);

    // Last word MSB 1 -> trail all zeros, then hs_en low.
    sc = 2;
    pre(0, 4, 1'b1);
    step(0, S_SYNC, 32'hB800, 1'b1, 32'h8001);
    step(0, S_DATA, 32'h8001, 1'b0, C_JUNK);
    tail(0, 32'h0000, 1'b0);
    step(0, S_IDLE, 0, 1'b0, C_JUNK);

    // One-cycle request pulse: preamble and sync still run, no payload.
    sc = 3;
    pre(0, 4, 1'b0);
    step(0, S_SYNC, 32'hB800, 1'b0, C_JUNK);
    tail(0, 32'h0000, 1'b0);
    step(0, S_IDLE, 0, 1'b0, C_JUNK);

    // Reset mid-burst.
    sc = 4;
    pre(0, 4, 1'b1);
    step(0, S_SYNC, 32'hB800, 1'b1, 32'hA5A5);
    rst = 1'b1;
    step(0, S_DATA, 32'hA5A5, 1'b1, 32'h1111);
    step(0, S_IDLE, 0, 1'b0, C_JUNK);
    rst = 1'b0;
    step(0, S_IDLE, 0, 1'b0, C_JUNK);

    // Back-to-back bursts; request stays high through trail/exit/idle.
    sc = 5;
    pre(0, 4, 1'b1);
    step(0, S_SYNC, 32'hB800, 1'b1, 32'h0101);
    step(0, S_DATA, 32'h0101, 1'b1, 32'h0202);
    step(0, S_DATA, 32'h0202, 1'b1, 32'h0303);
    step(0, S_DATA, 32'h0303, 1'b0, C_JUNK);
    tail(0, 32'hFFFF, 1'b1);
    pre(0, 4, 1'b1);
    step(0, S_SYNC, 32'hB800, 1'b1, 32'h0404);
    step(0, S_DATA, 32'h0404, 1'b1, 32'h0505);
    step(0, S_DATA, 32'h0505, 1'b1, 32'h8606);
    step(0, S_DATA, 32'h8606, 1'b0, C_JUNK);
    tail(0, 32'h0000, 1'b0);
    step(0, S_IDLE, 0, 1'b0, C_JUNK);

    // 32-bit lane with a single HS-zero cycle.
    sc = 6;
    pre(1, 1, 1'b1);
    step(1, S_SYNC, 32'hB800_0000, 1'b1, 32'h1234_5678);
    step(1, S_DATA, 32'h1234_5678, 1'b0, C_JUNK);
    tail(1, 32'hFFFF_FFFF, 1'b0);
    step(1, S_IDLE, 0, 1'b0, C_JUNK);

    @(negedge clk); #1;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
